// File: rtl/bridge_demux.sv
// bridge_demux
// Routes one CPU data-side access to one of four memory-mapped devices and
// steers the selected device's read data back with a one-cycle completion pulse.
// A wait-state counter turns a silent device into an error completion.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for cpu_req; decodes the address window when a request arrives
//   ACCESS | dev_sel asserted; waiting for the selected dev_ack or the wait limit
//   RESP   | cpu_ready pulse; cpu_err/cpu_rdata already hold the result
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request (cpu_req sampled only in IDLE)
//   cpu_ready/err/rdata      completion pulse, error flag, read data
//   busy                     high in ACCESS and RESP
//   dev_sel                  one-hot device select, held during ACCESS
//   dev_we/addr/wdata        latched request fields toward the devices
//   dev_ack                  per-device acknowledge (only selected bit honoured)
//   dev_rdata0..3            per-device read data
module bridge_demux #(
  parameter int          BIT_WIDTH = 32,
  parameter logic [19:0] WINDOW    = 20'h00007,
  parameter int          TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [BIT_WIDTH-1:0] cpu_wdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [BIT_WIDTH-1:0] cpu_rdata,
  output logic                 busy,
  output logic [3:0]           dev_sel,
  output logic                 dev_we,
  output logic [9:0]           dev_addr,
  output logic [BIT_WIDTH-1:0] dev_wdata,
  input  logic [3:0]           dev_ack,
  input  logic [BIT_WIDTH-1:0] dev_rdata0,
  input  logic [BIT_WIDTH-1:0] dev_rdata1,
  input  logic [BIT_WIDTH-1:0] dev_rdata2,
  input  logic [BIT_WIDTH-1:0] dev_rdata3
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Terminal count: wait_cnt holds (ACCESS cycle number - 1), so reaching
  // TIMEOUT-1 means the current cycle is the TIMEOUT-th ACCESS cycle.
  localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           idx;
  logic [7:0]           wait_cnt;
  logic                 window_hit;
  logic                 ack_hit;
  logic                 wait_tc;
  logic [BIT_WIDTH-1:0] sel_rdata;

  logic                 start_access;
  logic                 start_miss;
  logic                 done_ack;
  logic                 done_timeout;

  assign window_hit = (cpu_addr[31:12] == WINDOW);
  assign ack_hit    = dev_ack[idx];
  assign wait_tc    = (wait_cnt == WAIT_TC);

  always_comb begin
    sel_rdata = dev_rdata0;
    case (idx)
      2'd0:    sel_rdata = dev_rdata0;
      2'd1:    sel_rdata = dev_rdata1;
      2'd2:    sel_rdata = dev_rdata2;
      default: sel_rdata = dev_rdata3;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_nxt = window_hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (ack_hit || wait_tc) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    cpu_ready    = 1'b0;
    busy         = 1'b0;
    start_access = 1'b0;
    start_miss   = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state)
      IDLE: begin
        start_access = cpu_req && window_hit;
        start_miss   = cpu_req && !window_hit;
      end
      ACCESS: begin
        busy         = 1'b1;
        done_ack     = ack_hit;
        // An ack in the terminal cycle takes priority over the timeout.
        done_timeout = !ack_hit && wait_tc;
      end
      RESP: begin
        busy      = 1'b1;
        cpu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latches, device select, wait counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      wait_cnt  <= 8'd0;
      dev_sel   <= 4'b0000;
      dev_we    <= 1'b0;
      dev_addr  <= 10'd0;
      dev_wdata <= '0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (start_access) begin
        idx       <= cpu_addr[11:10];
        dev_sel   <= 4'b0001 << cpu_addr[11:10];
        dev_we    <= cpu_we;
        dev_addr  <= cpu_addr[9:0];
        dev_wdata <= cpu_wdata;
        wait_cnt  <= 8'd0;
      end
      if (start_miss) begin
        cpu_err   <= 1'b1;
        cpu_rdata <= '0;
      end
      if (done_ack) begin
        cpu_err   <= 1'b0;
        cpu_rdata <= dev_we ? '0 : sel_rdata;
        dev_sel   <= 4'b0000;
      end else if (done_timeout) begin
        cpu_err   <= 1'b1;
        cpu_rdata <= '0;
        dev_sel   <= 4'b0000;
      end else if (state == ACCESS) begin
        wait_cnt  <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bridge_demux.sv
module tb_bridge_demux;
  localparam int BW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [BW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic [BW-1:0] cpu_rdata;
  logic          busy;
  logic [3:0]    dev_sel;
  logic          dev_we;
  logic [9:0]    dev_addr;
  logic [BW-1:0] dev_wdata;
  logic [3:0]    dev_ack;
  logic [BW-1:0] dev_rdata0, dev_rdata1, dev_rdata2, dev_rdata3;

  always #5 clk = ~clk;

  bridge_demux #(.BIT_WIDTH(BW), .WINDOW(20'h00007), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .busy(busy),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack),
    .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1),
    .dev_rdata2(dev_rdata2), .dev_rdata3(dev_rdata3)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;   // cycle in which the selected device acks, 0 = never
    logic [3:0]  noise;     // non-selected ack bits held high throughout
    logic [31:0] rdata;     // data presented by the addressed device
    int          exp_lat;   // cycle of cpu_ready
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rdata(input logic [1:0] d, input logic [31:0] val);
    dev_rdata0 = ~val ^ 32'h0000_0010;
    dev_rdata1 = ~val ^ 32'h0000_0020;
    dev_rdata2 = ~val ^ 32'h0000_0040;
    dev_rdata3 = ~val ^ 32'h0000_0080;
    case (d)
      2'd0:    dev_rdata0 = val;
      2'd1:    dev_rdata1 = val;
      2'd2:    dev_rdata2 = val;
      default: dev_rdata3 = val;
    endcase
  endtask

  task automatic pop_and_check(input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_ready: got cpu_ready in cycle %0d, required no completion", cyc);
    end else begin
      e = sb.pop_front();
      check("latency", 32'(cyc), 32'(e.lat));
      check("cpu_err", 32'(cpu_err), 32'(e.err));
      check("cpu_rdata", cpu_rdata, e.rdata);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the access.
  task automatic run_txn(input vec_t v);
    logic [1:0] d;
    bit done;
    d = v.addr[11:10];
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    dev_ack   = 4'b0000;
    set_rdata(d, v.rdata);
    sb.push_back('{v.exp_err, v.exp_rdata, v.exp_lat});
    done = 1'b0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(posedge clk); #1;
      check("dev_sel", 32'(dev_sel), 32'((cyc < v.exp_lat) ? v.exp_sel : 4'b0000));
      check("busy", 32'(busy), 32'd1);
      if (cyc == 1 && v.exp_sel != 4'b0000) begin
        check("dev_we", 32'(dev_we), 32'(v.we));
        check("dev_addr", 32'(dev_addr), 32'(v.addr[9:0]));
        check("dev_wdata", dev_wdata, v.wdata);
      end
      if (cpu_ready) begin
        cpu_req = 1'b0;
        dev_ack = 4'b0000;
        pop_and_check(cyc);
        done = 1'b1;
      end else begin
        dev_ack = v.noise | ((cyc == v.ack_cyc) ? (4'b0001 << d) : 4'b0000);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no cpu_ready in 300 cycles, required one in cycle %0d", v.exp_lat);
      sb.delete();
      cpu_req = 1'b0;
      dev_ack = 4'b0000;
    end
    @(posedge clk); #1;
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    //               we    addr           wdata          ack noise    rdata          lat err exp_rdata      sel
    vecs[0] = '{1'b0, 32'h0000_7404, 32'h0,         1,  4'b0000, 32'hDEAD_BEEF, 2,  1'b0, 32'hDEAD_BEEF, 4'b0010};
    vecs[1] = '{1'b1, 32'h0000_7C10, 32'h1234_5678, 4,  4'b0000, 32'hCAFE_0001, 5,  1'b0, 32'h0,         4'b1000};
    vecs[2] = '{1'b0, 32'h0000_7800, 32'h0,         0,  4'b0001, 32'h5555_AAAA, 17, 1'b1, 32'h0,         4'b0100};
    vecs[3] = '{1'b0, 32'h0000_7000, 32'h0,         16, 4'b0000, 32'h0BAD_F00D, 17, 1'b0, 32'h0BAD_F00D, 4'b0001};
    vecs[4] = '{1'b0, 32'h0000_8000, 32'h0,         0,  4'b0000, 32'h1111_2222, 1,  1'b1, 32'h0,         4'b0000};
    vecs[5] = '{1'b0, 32'h0000_7C3C, 32'h0,         2,  4'b0111, 32'h8765_4321, 3,  1'b0, 32'h8765_4321, 4'b1000};
    vecs[6] = '{1'b1, 32'h0000_7004, 32'hA5A5_5A5A, 1,  4'b0000, 32'h7777_7777, 2,  1'b0, 32'h0,         4'b0001};
    vecs[7] = '{1'b1, 32'hFFFF_7000, 32'h0F0F_0F0F, 0,  4'b0000, 32'h3333_3333, 1,  1'b1, 32'h0,         4'b0000};
    vecs[8] = '{1'b0, 32'h0000_7400, 32'h0,         15, 4'b1101, 32'h0000_0042, 16, 1'b0, 32'h0000_0042, 4'b0010};

    // Reset with random inputs: every output must be 0.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req    = 1'($urandom);
      cpu_we     = 1'($urandom);
      cpu_addr   = $urandom;
      cpu_wdata  = $urandom;
      dev_ack    = 4'($urandom);
      dev_rdata0 = $urandom;
      dev_rdata1 = $urandom;
      dev_rdata2 = $urandom;
      dev_rdata3 = $urandom;
      #7;
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_cpu_err", 32'(cpu_err), 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dev_sel", 32'(dev_sel), 32'd0);
      check("rst_dev_we", 32'(dev_we), 32'd0);
      check("rst_dev_addr", 32'(dev_addr), 32'd0);
      check("rst_dev_wdata", dev_wdata, 32'd0);
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; dev_ack = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i]);
    end

    // Back-to-back: req held high through RESP starts the next access in the
    // following IDLE cycle, so completions land in cycles 2 and 5.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7404; dev_ack = 4'b0000;
    set_rdata(2'd1, 32'h1111_1111);
    sb.push_back('{1'b0, 32'h1111_1111, 2});
    @(posedge clk); #1;                        // cycle 1
    check("b2b_sel1", 32'(dev_sel), 32'h2);
    dev_ack = 4'b0010;
    @(posedge clk); #1;                        // cycle 2
    check("b2b_ready1", 32'(cpu_ready), 32'd1);
    if (cpu_ready) pop_and_check(2);
    dev_ack = 4'b0000;
    cpu_addr = 32'h0000_7C00;
    set_rdata(2'd3, 32'h3333_0003);
    sb.push_back('{1'b0, 32'h3333_0003, 5});
    @(posedge clk); #1;                        // cycle 3: IDLE, samples req
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;                        // cycle 4
    check("b2b_sel2", 32'(dev_sel), 32'h8);
    dev_ack = 4'b1000;
    @(posedge clk); #1;                        // cycle 5
    check("b2b_ready2", 32'(cpu_ready), 32'd1);
    if (cpu_ready) pop_and_check(5);
    cpu_req = 1'b0; dev_ack = 4'b0000;
    sb.delete();
    @(posedge clk); #1;

    // Reset asserted in cycle 2 of a device 1 access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7408; dev_ack = 4'b0000;
    @(posedge clk); #1;                        // cycle 1
    check("mid_sel1", 32'(dev_sel), 32'h2);
    @(posedge clk); #1;                        // cycle 2
    check("mid_sel2", 32'(dev_sel), 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(dev_sel), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst_ready", 32'(cpu_ready), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready", 32'(cpu_ready), 32'd0);
    end
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bridge_demux.md
# bridge_demux

Data-side bus bridge between the CPU memory stage and up to four memory-mapped peripherals. It decodes one CPU access and routes it to exactly one device slot. It then waits for that device's acknowledge and returns the selected read data with a single-cycle completion pulse. The bridge is the distributing counterpart of the datapath selectors: one request fans out to one of several devices, and one of several read-data buses is steered back. A wait-state counter turns a hung or absent device into an error completion instead of a stall.

## Interface
- BIT_WIDTH, 32, width of CPU/device data buses
- WINDOW, 20'h00007, value `cpu_addr[31:12]` must match for a mapped access (window 0x0000_7000–0x0000_7FFF)
- TIMEOUT, 16, ACCESS cycles allowed without ack before error completion; legal range 1..255
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cpu_req  input  1  access request, level; sampled only in IDLE
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  32  byte address
- cpu_wdata  input  BIT_WIDTH  write data
- cpu_ready  output  1  one-cycle completion pulse
- cpu_err  output  1  valid with cpu_ready; 1 = unmapped or timeout
- cpu_rdata  output  BIT_WIDTH  read data, valid with cpu_ready
- busy  output  1  high in ACCESS and RESP
- dev_sel  output  4  one-hot device select, held for the whole ACCESS phase
- dev_we  output  1  latched cpu_we
- dev_addr  output  10  latched `cpu_addr[9:0]`
- dev_wdata  output  BIT_WIDTH  latched cpu_wdata
- dev_ack  input  4  per-device acknowledge; only the selected bit is honoured
- dev_rdata0..dev_rdata3  input  BIT_WIDTH each  per-device read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cpu_req=1, window hit:
  - latch we/addr/wdata and device index `cpu_addr[11:10]`
  - set dev_sel to the one-hot of that index, clear the wait counter, go to ACCESS
- IDLE, cpu_req=1, window miss:
  - go to RESP with err=1 and rdata=0
  - dev_sel stays 0
- ACCESS, `dev_ack[idx]`=1:
  - on a read, capture `dev_rdata[idx]` into cpu_rdata; on a write, capture 0
  - err=0, dev_sel←0, go to RESP
- ACCESS, no ack:
  - counter+1
  - when this is the TIMEOUT-th ACCESS cycle: err=1, rdata=0, dev_sel←0, go to RESP
  - an ack in that same cycle wins over the timeout
- ACCESS: ack bits of non-selected devices are ignored entirely.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE. cpu_req is ignored during RESP.
- A cpu_req still high in IDLE after RESP starts a new access. The CPU deasserts cpu_req in the cycle after cpu_ready.
- cpu_rdata and cpu_err are registered. They are updated only on entry to RESP and hold their value otherwise.
- dev_we, dev_addr and dev_wdata hold their last latched values outside ACCESS.

## Timing
- Reset (async assert): state=IDLE, counter=0, and every output is 0 (cpu_ready, cpu_err, cpu_rdata, busy, dev_sel, dev_we, dev_addr, dev_wdata).
- Reset mid-access: dev_sel drops immediately and no completion pulse is produced. After release, the bridge idles until a new cpu_req.
- Request sampled at the end of cycle 0. In cycle 1, dev_sel is high and busy=1.
- Ack in cycle k (k≥1): cpu_ready high in cycle k+1; dev_sel low from cycle k+1.
- Minimum mapped latency: cpu_ready in cycle 2.
- Timeout: dev_sel high in cycles 1..TIMEOUT; cpu_ready with err=1 in cycle TIMEOUT+1.
- Unmapped access: cpu_ready with err=1 in cycle 1; no dev_sel activity.
- Back-to-back: with req held, the next access is sampled in the IDLE cycle after RESP. Throughput is at most one access per 3 cycles.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then req for 0x0000_7404 read with dev_ack[1] high in cycle 1 and dev_rdata1=0xDEADBEEF → dev_sel=4'b0010 in cycle 1 only; cpu_ready=1, err=0, rdata=0xDEADBEEF in cycle 2.
- Write to 0x0000_7C10, wdata=0x12345678, device 3 acks after 3 wait cycles → dev_sel=4'b1000 for cycles 1–4; dev_we=1, dev_addr=0x010, dev_wdata=0x12345678; cpu_ready in cycle 5 with rdata=0.
- Timeout, TIMEOUT=16, device 2 silent, dev_ack[0] pulsed → dev_sel=4'b0100 in cycles 1–16; cpu_ready=1, err=1, rdata=0 in cycle 17; the dev_ack[0] pulse has no effect.
- Ack in boundary cycle: device 0 acks in cycle 16 with TIMEOUT=16 → err=0 and the data is returned in cycle 17.
- Unmapped address 0x0000_8000 → cpu_ready=1 and err=1 in cycle 1; dev_sel stays 0 throughout.
- Async reset asserted in cycle 2 of a device 1 access → dev_sel=0 within the same cycle, no cpu_ready. The next request after release completes normally.
